// File: rtl/mem_req_ctrl.sv
// Request sequencer in front of the 8x8 memory FSM: queues valid/ready requests and issues them as
// single-cycle R/W strobes. Optional statistics counters: define MEM_REQ_CTRL_STATS_EN.
module mem_req_ctrl #(
  parameter int DW         = 8,
  parameter int AW         = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [DW-1:0]    req_wdata,
  output logic             rsp_valid,
  output logic [AW-1:0]    rsp_addr,
  output logic [DW-1:0]    rsp_data,
  output logic             busy,
  output logic             mem_R,
  output logic             mem_W,
  output logic [AW-1:0]    mem_adr,
  output logic [DW-1:0]    mem_i,
  input  logic [DW-1:0]    mem_o,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_EXEC, S_CAPT} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_t        state, state_d;
  req_t          fifo_mem [FIFO_DEPTH];
  req_t          head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, empty, push, pop;
  logic          cmd_we;
  logic          mem_r_d, mem_w_d, rsp_set;

  assign full      = (count == (PW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign req_ready = ~full;
  assign push      = req_valid & req_ready;
  assign pop       = (state == S_IDLE) & ~empty;
  assign head      = fifo_mem[rd_ptr];
  assign busy      = ~empty | (state != S_IDLE);

  // Pointers wrap for free because FIFO_DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; entry validity is carried by count alone.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= '{we: req_we, addr: req_addr, wdata: req_wdata};
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state;
    mem_r_d = 1'b0;
    mem_w_d = 1'b0;
    rsp_set = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_ISSUE;
          mem_r_d = ~head.we;
          mem_w_d = head.we;
        end
      end
      S_ISSUE: state_d = S_EXEC;
      S_EXEC:  state_d = cmd_we ? S_IDLE : S_CAPT;
      S_CAPT: begin
        state_d = S_IDLE;
        rsp_set = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered so they are high exactly for the ISSUE cycle.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= S_IDLE;
      mem_R     <= 1'b0;
      mem_W     <= 1'b0;
      cmd_we    <= 1'b0;
      mem_adr   <= '0;
      mem_i     <= '0;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
    end else begin
      state     <= state_d;
      mem_R     <= mem_r_d;
      mem_W     <= mem_w_d;
      rsp_valid <= rsp_set;
      if (pop) begin
        cmd_we  <= head.we;
        mem_adr <= head.addr;
        mem_i   <= head.wdata;
      end
      if (rsp_set) begin
        rsp_data <= mem_o;
        rsp_addr <= mem_adr;
      end
    end
  end

`ifdef MEM_REQ_CTRL_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (rsp_valid && rd_cnt != CNT_MAX)                      rd_cnt <= rd_cnt + CNT_W'(1);
      if (state == S_EXEC && cmd_we && wr_cnt != CNT_MAX)      wr_cnt <= wr_cnt + CNT_W'(1);
    end
  end
`else
  assign rd_cnt = '0;
  assign wr_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a behavioural 8x8 memory attached to the strobe bus.
module tb_mem_req_ctrl;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int CNT_W = 8;

  logic             CLK = 1'b0;
  logic             RSTn = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_we = 1'b0;
  logic [AW-1:0]    req_addr = '0;
  logic [DW-1:0]    req_wdata = '0;
  logic             rsp_valid;
  logic [AW-1:0]    rsp_addr;
  logic [DW-1:0]    rsp_data;
  logic             busy;
  logic             mem_R, mem_W;
  logic [AW-1:0]    mem_adr;
  logic [DW-1:0]    mem_i;
  logic [DW-1:0]    mem_o = '0;
  logic [CNT_W-1:0] rd_cnt, wr_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0]       mem_model [8];
  logic [AW+DW-1:0]    wr_log [$];
  logic [AW+DW-1:0]    rsp_log [$];
  int                  rd_strobes = 0;
  int                  both_cnt = 0;
  bit                  saw_not_ready = 1'b0;

  mem_req_ctrl #(.DW(DW), .AW(AW), .FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .busy(busy), .mem_R(mem_R), .mem_W(mem_W), .mem_adr(mem_adr),
    .mem_i(mem_i), .mem_o(mem_o), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 CLK = ~CLK;

  // Memory model: write on strobe, read data presented the cycle after the read strobe.
  always @(posedge CLK) begin
    if (mem_W) mem_model[mem_adr] <= mem_i;
    if (mem_R) mem_o <= mem_model[mem_adr];
  end

  always @(negedge CLK) begin
    if (mem_W) wr_log.push_back({mem_adr, mem_i});
    if (mem_R) rd_strobes++;
    if (mem_R && mem_W) both_cnt++;
    if (rsp_valid) rsp_log.push_back({rsp_addr, rsp_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a request at a falling edge and hold it until accepted; returns one cycle after acceptance.
  task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 100) begin
      saw_not_ready = 1'b1;
      @(negedge CLK);
      n++;
    end
    if (n == 100) check("push_ready_timeout", 32'(req_ready), 32'd1);
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (n == 300) check("idle_timeout", 32'(busy), 32'd0);
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int strobes_before;
    for (int i = 0; i < 8; i++) mem_model[i] = '0;

    // 1: reset state
    repeat (3) @(negedge CLK);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", {30'd0, mem_R, mem_W}, 32'd0);
    check("rst_rsp", {20'd0, rsp_valid, rsp_addr, rsp_data}, 32'd0);
    check("rst_mem_bus", {21'd0, mem_adr, mem_i}, 32'd0);
    check("rst_cnts", {16'd0, rd_cnt, wr_cnt}, 32'd0);
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);
    check("post_rst_idle", {29'd0, busy, mem_R, mem_W}, 32'd0);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // 2: write 0xA5 @3, then read @3
    push(1'b1, 3'd3, 8'hA5);
    check("wr_lat_c1", 32'(mem_W), 32'd0);
    @(negedge CLK);
    check("wr_issue_W", 32'(mem_W), 32'd1);
    check("wr_issue_R", 32'(mem_R), 32'd0);
    check("wr_issue_adr", 32'(mem_adr), 32'd3);
    check("wr_issue_i", 32'(mem_i), 32'hA5);
    @(negedge CLK);
    check("wr_exec_W", 32'(mem_W), 32'd0);
    check("wr_exec_adr", 32'(mem_adr), 32'd3);
    @(negedge CLK);
    check("wr_done_busy", 32'(busy), 32'd0);
    push(1'b0, 3'd3, 8'h00);
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("rd_latency", 32'(n), 32'd5);
    check("rd_data", 32'(rsp_data), 32'hA5);
    check("rd_addr", 32'(rsp_addr), 32'd3);
    @(negedge CLK);
    check("rsp_pulse", 32'(rsp_valid), 32'd0);
    check("rsp_hold", 32'(rsp_data), 32'hA5);

    // 3: burst writes overfilling the FIFO
    wait_idle();
    wr_log.delete();
    saw_not_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(1'b1, AW'(i), 8'h30 + 8'(i));
    check("full_ready_low", 32'(req_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    push(1'b1, 3'd6, 8'h36);
    check("burst_backpressure", 32'(saw_not_ready), 32'd1);
    wait_idle();
    check("burst_count", 32'(wr_log.size()), 32'd7);
    for (int i = 0; i < 7 && i < wr_log.size(); i++)
      check($sformatf("burst_order[%0d]", i), 32'(wr_log[i]), 32'({AW'(i), 8'h30 + 8'(i)}));

    // 4: writes @0..7, reads @7..0
    rsp_log.delete();
    for (int i = 0; i < 8; i++) push(1'b1, AW'(i), 8'h10 + 8'(i));
    for (int i = 7; i >= 0; i--) push(1'b0, AW'(i), 8'h00);
    wait_idle();
    check("rd8_count", 32'(rsp_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < rsp_log.size(); i++)
      check($sformatf("rd8_rsp[%0d]", i), 32'(rsp_log[i]), 32'({AW'(7 - i), 8'h10 + 8'(7 - i)}));

    // 5: reset during EXEC of a read with two reads queued
    rsp_log.delete();
    push(1'b0, 3'd1, 8'h00);
    push(1'b0, 3'd2, 8'h00);
    push(1'b0, 3'd3, 8'h00);
    check("abort_pre_busy", 32'(busy), 32'd1);
    strobes_before = rd_strobes;
    RSTn = 1'b0;
    #1;
    check("abort_strobes", {30'd0, mem_R, mem_W}, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    repeat (10) @(negedge CLK);
    check("abort_no_rsp", 32'(rsp_log.size()), 32'd0);
    check("abort_no_reissue", 32'(rd_strobes - strobes_before), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);

    // 6: statistics
    push(1'b1, 3'd4, 8'h44);
    push(1'b1, 3'd5, 8'h45);
    push(1'b1, 3'd6, 8'h46);
    push(1'b0, 3'd4, 8'h00);
    push(1'b0, 3'd6, 8'h00);
    wait_idle();
    check("stats_rsp_count", 32'(rsp_log.size()), 32'd2);
    if (rsp_log.size() == 2) begin
      check("stats_rsp0", 32'(rsp_log[0]), 32'({3'd4, 8'h44}));
      check("stats_rsp1", 32'(rsp_log[1]), 32'({3'd6, 8'h46}));
    end
`ifdef MEM_REQ_CTRL_STATS_EN
    check("wr_cnt", 32'(wr_cnt), 32'd3);
    check("rd_cnt", 32'(rd_cnt), 32'd2);
`else
    check("wr_cnt_off", 32'(wr_cnt), 32'd0);
    check("rd_cnt_off", 32'(rd_cnt), 32'd0);
`endif

    check("never_both_strobes", 32'(both_cnt), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
